tone_sequencer: RTL
===================

# tone_sequencer

Melody controller for the buzzer tone selector: steps through a small writable table of note entries, driving the 2-bit note select `state` and a `tone_en` gate for the buzzer path, holding each note for a programmed number of 10 ms ticks with a silent articulation gap between notes. It sits between the button/host logic and the tone-select mux, replacing hard-wired `state` switches with timed playback. Supports one-shot and looped playback, start/stop control, and table writes at any time.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency
- `TICK_HZ`, 100, duration tick rate; `TICK_DIV = CLK_HZ/TICK_HZ` (≥2)
- `DEPTH`, 8, table entries (power of 2)
- `DUR_W`, 6, duration field width in ticks
- `GAP_TICKS`, 1, silent ticks between notes (0 = no gap)

- `clk_50MHz` in 1 — system clock
- `rst_n` in 1 — synchronous, active-low reset
- `start` in 1 — single-cycle pulse, begin playback at entry 0
- `stop` in 1 — single-cycle pulse, abort playback
- `loop` in 1 — level; at end of melody restart from entry 0
- `wr_en` in 1 — table write strobe
- `wr_addr` in log2(DEPTH) — entry index
- `wr_data` in DUR_W+3 — {rest[1], note[1:0], dur[DUR_W-1:0]}; dur=0 is end marker
- `state` out 2 — note select to tone mux (00/01/10/11 = 261/277/493/523 Hz)
- `tone_en` out 1 — buzzer gate, high while a non-rest note plays
- `busy` out 1 — high from LOAD through last GAP
- `done` out 1 — one-cycle pulse on natural melody end
- `play_idx` out log2(DEPTH) — entry currently loaded

## Operation
- Reset: all outputs 0, FSM IDLE, table cleared to 0 (all end markers).
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE: `start` → LOAD, idx=0. `busy`=0, `tone_en`=0.
- LOAD (one cycle): read entry[idx]. dur≠0 → PLAY; registered `state`=note, `tone_en`=~rest, dur counter=dur, prescaler cleared. dur=0 (end): if `loop` and idx≠0 → idx=0, stay LOAD; else `done` pulse, → IDLE.
- PLAY: counter decrements per tick; on tick with counter=1 → GAP (or directly next-entry step if GAP_TICKS=0).
- GAP: `tone_en`=0, `state` held; after GAP_TICKS ticks → idx+1, LOAD. idx=DEPTH-1 advancing is treated as end marker (same loop/done rule).
- `stop` in any state → IDLE next cycle, `tone_en`=0, `busy`=0, no `done`; `state` retains last value.
- `stop` and `start` same cycle: stop wins. `start` while busy: ignored.
- Writes take effect on the next LOAD of that entry; playing entry is not disturbed.
- Empty melody (entry 0 end marker): start → LOAD → `done`, IDLE, `tone_en` never asserts, even with `loop`=1.

## Timing
- `start` sampled at cycle n → LOAD at n+1 → `tone_en`/`state` valid at n+2.
- Tick pulse when prescaler = TICK_DIV-1; prescaler restarts at 0 on entering PLAY and GAP.
- Note of duration D: `tone_en` high exactly D·TICK_DIV cycles; gap exactly GAP_TICKS·TICK_DIV cycles; one LOAD cycle between gap end and next note.
- `done` asserts the cycle after the final LOAD sees the end condition; `busy` falls same cycle.
- All outputs registered; no combinational input→output paths.

## Structure
- Package `tone_seq_pkg`: note code constants (NOTE_C4=00, NOTE_CS4=01, NOTE_B4=10, NOTE_C5=11), FSM state encoding, entry field offsets/widths.
- Sub-module `tick_prescaler` (count to TICK_DIV-1, sync clear input, tick output).
- Table as register array in the top level (DEPTH small; no RAM inference).

## Test plan
(sim with CLK_HZ=400, TICK_HZ=100 → TICK_DIV=4, GAP_TICKS=1)
- Write {0,00,3},{0,11,2},{0,00,0}; start, loop=0 → state 00 tone_en high 12 cycles, low 4, state 11 high 8 cycles, low 4, `done` pulse, busy low.
- Same table, loop=1 → sequence repeats; entry 0 reloaded one cycle after end-marker LOAD; no `done`.
- Entry {1,10,2} (rest) → state=10, tone_en low 8 cycles, busy high throughout.
- `stop` mid-note, and `stop`+`start` same cycle → IDLE next cycle, tone_en=0, no done; second case stays IDLE.
- All 8 entries nonzero → after entry 7 gap, `done` pulse (wrap treated as end); with loop=1, restarts at entry 0.
- Empty table, start with loop=1 → `done` at start+2, tone_en never high; rst_n low mid-PLAY → all outputs 0 next cycle, table cleared.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: note codes, sequencer FSM encoding and note-table entry layout
package tone_seq_pkg;
  localparam logic [1:0] NOTE_C4 = 2'b00;
  localparam logic [1:0] NOTE_CS4 = 2'b01;
  localparam logic [1:0] NOTE_B4 = 2'b10;
  localparam logic [1:0] NOTE_C5 = 2'b11;
  localparam int NOTE_W = 2;
  localparam int REST_W = 1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} fsm_e;
  function automatic int entry_w(input int dur_w);
    return dur_w + NOTE_W + REST_W;
  endfunction
endpackage

// File: rtl/tone_sequencer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every DIV clocks, restartable so each phase gets whole ticks
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(DIV - 1);
  // wrap after the tick cycle; clear restarts the count at phase entry
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + W'(1);
  // count register
  always_ff @(posedge clk_i) cnt_q <= !rst_n_i ? '0 : cnt_d;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: timed playback of a writable note table onto the buzzer tone select
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DEPTH     = 8,
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic                     clk_50MHz,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DUR_W+2:0]         wr_data,
  output logic [1:0]               state,
  output logic                     tone_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] play_idx
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(DUR_W);
  localparam logic [DUR_W-1:0] GAP_N = DUR_W'(GAP_TICKS);
  logic [EW-1:0] tbl_q [DEPTH];
  fsm_e fsm_q, fsm_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d;
  logic [1:0] state_q, state_d;
  logic tone_en_q, tone_en_d, busy_q, busy_d, done_q, done_d;
  logic tick, end_seg, at_end, relo, presc_clr;
  logic [DUR_W-1:0] e_dur;
  logic [NOTE_W-1:0] e_note;
  logic e_rest;
  assign {e_rest, e_note, e_dur} = tbl_q[idx_q];
  assign end_seg = tick && cnt_q == DUR_W'(1);
  // wrap_q marks that the last slot finished, which ends the melody like an end marker
  assign at_end = wrap_q || e_dur == '0;
  // looping restarts from entry 0 unless entry 0 itself is the end (empty melody)
  assign relo = loop && idx_q != '0;
  assign presc_clr = fsm_d != fsm_q;
  assign state = state_q;
  assign tone_en = tone_en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign play_idx = idx_q;
  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk_i  (clk_50MHz),
    .rst_n_i(rst_n),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );
  // note table: cleared to end markers on reset; writes are only observed at LOAD
  always_ff @(posedge clk_50MHz)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    else if (wr_en) tbl_q[wr_addr] <= wr_data;
  // FSM state and registered outputs
  always_ff @(posedge clk_50MHz)
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      state_q   <= NOTE_C4;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      state_q   <= state_d;
      tone_en_q <= tone_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  // next state: one counter times both note length and gap, in ticks
  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    wrap_d = wrap_q;
    if (stop) fsm_d = S_IDLE;
    else case (fsm_q)
      S_IDLE: if (start) begin
        fsm_d = S_LOAD;
        idx_d = '0;
        wrap_d = 1'b0;
      end
      S_LOAD: begin
        fsm_d = !at_end ? S_PLAY : relo ? S_LOAD : S_IDLE;
        idx_d = (at_end && relo) ? '0 : idx_q;
        cnt_d = e_dur;
        wrap_d = 1'b0;
      end
      S_PLAY, S_GAP: if (tick) begin
        cnt_d = cnt_q - DUR_W'(1);
        if (end_seg) begin
          if (fsm_q == S_PLAY && GAP_TICKS != 0) begin
            fsm_d = S_GAP;
            cnt_d = GAP_N;
          end else begin
            fsm_d = S_LOAD;
            wrap_d = &idx_q;
            idx_d = wrap_d ? idx_q : idx_q + AW'(1);
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end
  // outputs: note latched at LOAD, gate dropped at note end or stop, done on natural end only
  always_comb begin
    state_d = (fsm_q == S_LOAD && !at_end && !stop) ? e_note : state_q;
    tone_en_d = stop ? 1'b0 : (fsm_q == S_LOAD && !at_end) ? !e_rest : (fsm_q == S_PLAY && end_seg) ? 1'b0 : tone_en_q;
    busy_d = fsm_d != S_IDLE;
    done_d = !stop && fsm_q == S_LOAD && at_end && !relo;
  end
endmodule
